// File: rtl/blink_scheduler.sv
// Round-robin arbiter sharing one LED between four requesters: each grant plays
// N blinks, then a dark gap, then pulses DONE back to the winner.
module blink_scheduler #(
  parameter int HALF_PERIOD = 5,
  parameter int GAP_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [3:0]  REQ,
  input  logic [15:0] BLINKS,
  output logic [3:0]  GNT,
  output logic [3:0]  DONE,
  output logic        BUSY,
  output logic        LEDG
);

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       rem_q, rem_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       win_q, win_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [3:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             ledg_q, ledg_d;

  logic             reqFound;
  logic [1:0]       reqIdx;
  logic [3:0]       reqBlinks;
  logic             halfEnd;
  logic             gapEnd;

  // Search upward from the pointer, wrapping mod 4; the first set bit wins.
  always_comb begin
    reqFound = 1'b0;
    reqIdx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!reqFound && REQ[ptr_q + 2'(k)]) begin
        reqFound = 1'b1;
        reqIdx   = ptr_q + 2'(k);
      end
    end
  end

  assign reqBlinks = BLINKS[{reqIdx, 2'b00} +: 4];
  assign halfEnd   = (cnt_q == CNT_W'(HALF_PERIOD - 1));
  assign gapEnd    = (cnt_q == CNT_W'(GAP_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = 4'b0000;
    busy_d  = busy_q;
    ledg_d  = ledg_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (reqFound) begin
          win_d  = reqIdx;
          gnt_d  = 4'b0001 << reqIdx;
          busy_d = 1'b1;
          rem_d  = reqBlinks;
          if (reqBlinks != 4'd0) begin
            state_d = ON;
            ledg_d  = 1'b1;
          end else begin
            state_d = GAP;
            ledg_d  = 1'b0;
          end
        end
      end
      ON: begin
        if (halfEnd) begin
          state_d = OFF;
          cnt_d   = '0;
          ledg_d  = 1'b0;
        end
      end
      OFF: begin
        // A blink is counted as finished at the end of its dark half.
        if (halfEnd) begin
          rem_d = rem_q - 4'd1;
          cnt_d = '0;
          if (rem_q != 4'd1) begin
            state_d = ON;
            ledg_d  = 1'b1;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gapEnd) begin
          state_d = IDLE;
          cnt_d   = '0;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          done_d  = 4'b0001 << win_q;
          ptr_d   = win_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= 4'd0;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      done_q  <= 4'b0000;
      busy_q  <= 1'b0;
      ledg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ledg_q  <= ledg_d;
    end
  end

  assign GNT  = gnt_q;
  assign DONE = done_q;
  assign BUSY = busy_q;
  assign LEDG = ledg_q;

endmodule
